decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - Decode stage of the pipelined RV32I core, directly upstream of Execute.
// - Latches the fetched instruction, splits opcode/func3/func7/rd, builds the sign-extended immediate
//   and reads rs1/rs2 from an internal 32x32 register file (write port driven by writeback).
// - Handles valid/ready flow control toward fetch and Execute, load-use bubble insertion and flush.
// PARAMETERS
// - XLEN      32  data/address width (matches DataWidth/AddrWidth)
// - REG_COUNT 32  architectural registers; x0 hardwired to 0
// PORTS
// - clk            in   1      clock; all state updates on posedge
// - reset          in   1      synchronous, active-high
// - if_valid       in   1      fetch presents if_instr/if_pc
// - if_instr       in   32     raw instruction word
// - if_pc          in   32     PC of if_instr
// - if_ready       out  1      stage accepts instruction this cycle
// - ex_ready       in   1      Execute consumes current output this cycle
// - flush          in   1      taken branch/jump: kill held and incoming instruction
// - wb_en          in   1      register-file write enable
// - wb_rd          in   5      write index
// - wb_data        in   32     write data
// - id_valid       out  1      outputs below are valid
// - opcode         out  7      instr[6:0]
// - func3          out  3      instr[14:12]
// - func7          out  7      instr[31:25]
// - rd             out  5      instr[11:7]
// - regReadData0   out  32     rs1 value
// - regReadData1a  out  32     rs2 value (ALU operand)
// - regReadData1b  out  32     rs2 value (store data; always equal to 1a)
// - imm            out  32     decoded immediate
// - pc_out         out  32     PC of output instruction
// - illegal        out  1      opcode not one of the 9 RV32I base opcodes handled by Execute
// BEHAVIOUR
// - Reset: id_valid=0, every data output 0, all 32 registers cleared to 0.
// - Accept = if_valid && if_ready; if_ready = (!id_valid || ex_ready) && !hazard && !flush.
// - Latency 1: accepted instruction appears on outputs next cycle with id_valid=1.
// - Hold: id_valid && !ex_ready -> all outputs stable; only operand refresh (below) may change them.
// - If output consumed (ex_ready) and nothing accepted -> id_valid=0 next cycle.
// - Immediate (sign bit instr[31]): I(0010011,0000011,1100111) {20s,[31:20]}; S {20s,[31:25],[11:7]};
//   B {19s,[31],[7],[30:25],[11:8],0}; U(0110111,0010111) {[31:12],12'b0}; J {11s,[31],[19:12],[20],[30:21],0};
//   R/other -> 0. Shift-immediates keep raw [31:20], so imm[10]=instr[30] selects srai.
// - Source use: rs1 (instr[19:15]) for all except U/J; rs2 (instr[24:20]) for R, S, B only.
// - Load-use hazard: output holds valid load (opcode 0000011), rd!=0, and incoming instr uses rd as rs1/rs2
//   -> if_ready=0; when that load is consumed, id_valid=0 next cycle (one bubble), then instr accepted.
// - Register file: write on posedge when wb_en && wb_rd!=0; reads combinational; index 0 reads 0.
// - Operand refresh: while held, if wb_en && wb_rd!=0 matches latched rs1/rs2, that operand takes wb_data.
// - Flush (priority below reset only): id_valid=0 next cycle, incoming instruction dropped,
//   register-file write still performed.
// - Illegal opcode: still passed with id_valid=1 and illegal=1; Execute treats it as IDLE.
// CONFIGURATION
// - DECODE_BYPASS_EN defined: on capture, if wb_en && wb_rd!=0 && wb_rd==rs, capture wb_data (write-through).
// - Not defined: capture reads the pre-write register value; writeback must lead decode by one cycle.
// TESTING
// - reset, then addi x1,x0,5 (0x00500093) -> next cycle id_valid=1, opcode=0x13, rd=1, imm=5, rs1 data=0.
// - beq imm -8 (0xFE000CE3) -> imm=0xFFFFFFF8; sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, 1a==1b.
// - lw x3,0(x1) then add x4,x3,x3 -> if_ready=0 one cycle, one id_valid=0 bubble, add follows.
// - wb_en=1 wb_rd=7 wb_data=0xDEAD with same-cycle capture of rs1=x7 -> 0xDEAD iff DECODE_BYPASS_EN, else old.
// - ex_ready=0 for 3 cycles -> outputs stable; flush during hold -> id_valid=0 next cycle, no stale issue.
// - wb_rd=0 wb_data=0x1234 -> later read of x0 returns 0; reset mid-hold -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage sitting between fetch and Execute.
// Latches one instruction, splits its fields, builds the immediate and reads
// rs1/rs2 from an internal register file written by writeback.
// Optional feature macro: DECODE_BYPASS_EN (writeback-to-capture write-through).
//
// Handshake: a transfer happens on a posedge where valid && ready are both high.
// Fetch side: if_valid/if_ready. Execute side: id_valid/ex_ready. A holder of
// valid never drops it or changes its payload until the transfer happens,
// except that flush and reset kill the held instruction.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] regReadData0,
  output logic [XLEN-1:0] regReadData1a,
  output logic [XLEN-1:0] regReadData1b,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Shift-immediates fall into the I-type case, so imm[10] carries instr[30].
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] i);
    case (i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm_gen = {{(XLEN-12){i[31]}}, i[31:20]};
      OP_STORE:                 imm_gen = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:                imm_gen = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm_gen = {i[31:12], 12'b0};
      OP_JAL:                   imm_gen = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default:                  imm_gen = '0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    uses_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    uses_rs2 = (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  logic [XLEN-1:0] rf [REG_COUNT];

  logic            valid_q;
  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic [6:0]      f7_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_val_q;
  logic [XLEN-1:0] rs2_val_q;
  logic [4:0]      rs1_idx_q;
  logic [4:0]      rs2_idx_q;
  logic            illegal_q;

  // Source indices are forced to x0 when the format does not read that operand,
  // so unused fields never raise hazards, refreshes or bypasses.
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic            hazard;
  logic            accept;
  logic            wb_hit;
  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;

  assign in_rs1 = uses_rs1(if_instr[6:0]) ? if_instr[19:15] : 5'd0;
  assign in_rs2 = uses_rs2(if_instr[6:0]) ? if_instr[24:20] : 5'd0;
  assign wb_hit = wb_en && (wb_rd != 5'd0);

  // A held load whose rd feeds the incoming instruction must leave first.
  assign hazard = valid_q && (op_q == OP_LOAD) && (rd_q != 5'd0) && if_valid &&
                  ((in_rs1 == rd_q) || (in_rs2 == rd_q));
  assign if_ready = (!valid_q || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;

`ifdef DECODE_BYPASS_EN
  assign cap_rs1 = (wb_hit && (wb_rd == in_rs1)) ? wb_data : rf[in_rs1];
  assign cap_rs2 = (wb_hit && (wb_rd == in_rs2)) ? wb_data : rf[in_rs2];
`else
  assign cap_rs1 = rf[in_rs1];
  assign cap_rs2 = rf[in_rs2];
`endif

  // Register file: cleared on reset, x0 never written so it always reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Output register: capture, drain, or hold with operand refresh from writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      op_q      <= if_instr[6:0];
      f3_q      <= if_instr[14:12];
      f7_q      <= if_instr[31:25];
      rd_q      <= if_instr[11:7];
      imm_q     <= imm_gen(if_instr);
      pc_q      <= if_pc;
      rs1_val_q <= cap_rs1;
      rs2_val_q <= cap_rs2;
      rs1_idx_q <= in_rs1;
      rs2_idx_q <= in_rs2;
      illegal_q <= !is_legal(if_instr[6:0]);
    end else if (valid_q && ex_ready) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      if (wb_hit && (wb_rd == rs1_idx_q)) rs1_val_q <= wb_data;
      if (wb_hit && (wb_rd == rs2_idx_q)) rs2_val_q <= wb_data;
    end
  end

  assign id_valid      = valid_q;
  assign opcode        = op_q;
  assign func3         = f3_q;
  assign func7         = f7_q;
  assign rd            = rd_q;
  assign imm           = imm_q;
  assign pc_out        = pc_q;
  assign regReadData0  = rs1_val_q;
  assign regReadData1a = rs2_val_q;
  assign regReadData1b = rs2_val_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table for field/immediate/operand decode,
// plus hand-written sequences for load-use, write-through, hold, flush and reset.
module tb_decode_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc    = '0;
  logic        if_ready;
  logic        ex_ready = 1'b1;
  logic        flush    = 1'b0;
  logic        wb_en    = 1'b0;
  logic [4:0]  wb_rd    = '0;
  logic [31:0] wb_data  = '0;
  logic        id_valid;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [31:0] regReadData0;
  logic [31:0] regReadData1a;
  logic [31:0] regReadData1b;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        illegal;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .ex_ready(ex_ready), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .opcode(opcode), .func3(func3), .func7(func7), .rd(rd),
    .regReadData0(regReadData0), .regReadData1a(regReadData1a), .regReadData1b(regReadData1b),
    .imm(imm), .pc_out(pc_out), .illegal(illegal)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1; if_instr = instr; if_pc = pc; ex_ready = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic        ill;
  } vec_t;

  vec_t vecs[12];
  int   stalls;
  int   bubbles;
  logic [31:0] exp_bypass;

  initial begin
    // register contents preloaded below: x1=0x100 x2=0x55 x3=0x33 x7=0x77 x31=0x31
    vecs[0]  = '{32'h00500093, 7'h13, 3'd0, 7'h00, 5'd1,  32'h00000005, 32'h0,   32'h0,  1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'hFE000CE3, 7'h63, 3'd0, 7'h7F, 5'd25, 32'hFFFFFFF8, 32'h0,   32'h0,  1'b0}; // beq -8
    vecs[2]  = '{32'hFE20AE23, 7'h23, 3'd2, 7'h7F, 5'd28, 32'hFFFFFFFC, 32'h100, 32'h55, 1'b0}; // sw x2,-4(x1)
    vecs[3]  = '{32'h123452B7, 7'h37, 3'd5, 7'h09, 5'd5,  32'h12345000, 32'h0,   32'h0,  1'b0}; // lui x5
    vecs[4]  = '{32'h001000EF, 7'h6F, 3'd0, 7'h00, 5'd1,  32'h00000800, 32'h0,   32'h0,  1'b0}; // jal x1,+2048
    vecs[5]  = '{32'hFFFFF06F, 7'h6F, 3'd7, 7'h7F, 5'd0,  32'hFFFFFFFE, 32'h0,   32'h0,  1'b0}; // jal x0,-2
    vecs[6]  = '{32'h4030D313, 7'h13, 3'd5, 7'h20, 5'd6,  32'h00000403, 32'h100, 32'h0,  1'b0}; // srai x6,x1,3
    vecs[7]  = '{32'h00218233, 7'h33, 3'd0, 7'h00, 5'd4,  32'h00000000, 32'h33,  32'h55, 1'b0}; // add x4,x3,x2
    vecs[8]  = '{32'hFFF100E7, 7'h67, 3'd0, 7'h7F, 5'd1,  32'hFFFFFFFF, 32'h55,  32'h0,  1'b0}; // jalr x1,-1(x2)
    vecs[9]  = '{32'hFFFFFFFF, 7'h7F, 3'd7, 7'h7F, 5'd31, 32'h00000000, 32'h31,  32'h0,  1'b1}; // illegal
    vecs[10] = '{32'hFFFFF517, 7'h17, 3'd7, 7'h7F, 5'd10, 32'hFFFFF000, 32'h0,   32'h0,  1'b0}; // auipc x10
    vecs[11] = '{32'h0000A183, 7'h03, 3'd2, 7'h00, 5'd3,  32'h00000000, 32'h100, 32'h0,  1'b0}; // lw x3,0(x1)

    // ---- reset ----
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ctrl", {id_valid, illegal, if_ready}, 3'b001);
    chk("rst_fields", {opcode, func3, func7, rd}, 22'h0);
    chk("rst_imm_pc", {imm, pc_out}, 64'h0);
    chk("rst_rs1", regReadData0, 32'h0);
    chk("rst_rs2", {regReadData1a, regReadData1b}, 64'h0);
    @(negedge clk);

    // ---- preload register file ----
    wb_write(5'd1, 32'h100);
    wb_write(5'd2, 32'h55);
    wb_write(5'd3, 32'h33);
    wb_write(5'd7, 32'h77);
    wb_write(5'd31, 32'h31);

    // ---- table-driven decode ----
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].instr, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_valid", i), id_valid, 1'b1);
      chk($sformatf("v%0d_opcode", i), opcode, vecs[i].op);
      chk($sformatf("v%0d_func3", i), func3, vecs[i].f3);
      chk($sformatf("v%0d_func7", i), func7, vecs[i].f7);
      chk($sformatf("v%0d_rd", i), rd, vecs[i].rd);
      chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d_pc", i), pc_out, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_rs1", i), regReadData0, vecs[i].rs1v);
      chk($sformatf("v%0d_rs2a", i), regReadData1a, vecs[i].rs2v);
      chk($sformatf("v%0d_rs2b", i), regReadData1b, vecs[i].rs2v);
      chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
    end
    @(negedge clk);
    chk("drain_valid", id_valid, 1'b0);

    // ---- load-use: lw x3,0(x1) then add x4,x3,x3 ----
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h2004);
    issue(32'h0000A183, 32'h2000);
    if_valid = 1'b1; if_instr = 32'h00318233; if_pc = 32'h2004;
    stalls = 0; bubbles = 0;
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      #1;
      if (if_valid && !if_ready) stalls++;
      if (id_valid) begin
        chk("lu_order", pc_out, exp_q.pop_front());
        if (pc_out == 32'h2004) if_valid = 1'b0;
      end else begin
        bubbles++;
      end
      @(negedge clk);
    end
    if_valid = 1'b0;
    chk("lu_drained", exp_q.size(), 0);
    chk("lu_stalls", stalls, 1);
    chk("lu_bubbles", bubbles, 1);

    // ---- writeback in the same cycle as capture of rs1=x7 ----
`ifdef DECODE_BYPASS_EN
    exp_bypass = 32'hDEAD;
`else
    exp_bypass = 32'h77;
`endif
    if_valid = 1'b1; if_instr = 32'h00038413; if_pc = 32'h3000; ex_ready = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
    @(negedge clk);
    wb_en = 1'b0; if_valid = 1'b0;
    chk("capture_rs1_x7", regReadData0, exp_bypass);
    issue(32'h00038413, 32'h3004);
    chk("rf_x7_written", regReadData0, 32'hDEAD);

    // ---- write to x0 is discarded ----
    wb_write(5'd0, 32'h1234);
    issue(32'h00500093, 32'h3008);
    chk("x0_reads_zero", regReadData0, 32'h0);

    // ---- hold for 3 cycles with refresh of rs2=x2, then flush ----
    issue(32'h00218233, 32'h4000);
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'hFFF100E7; if_pc = 32'h4004;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready", if_ready, 1'b0);
      chk("hold_valid", id_valid, 1'b1);
      chk("hold_fields", {opcode, rd, func3, func7, pc_out}, {7'h33, 5'd4, 3'd0, 7'h00, 32'h4000});
      chk("hold_rs1", regReadData0, 32'h33);
      chk("hold_rs2", {regReadData1a, regReadData1b}, (c == 2) ? {32'h99, 32'h99} : {32'h55, 32'h55});
      if (c == 1) begin
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h99;
      end else begin
        wb_en = 1'b0;
      end
      @(negedge clk);
    end
    flush = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555;
    #1;
    chk("flush_ready", if_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; wb_en = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    chk("flush_valid", id_valid, 1'b0);
    @(negedge clk);
    chk("flush_no_stale", id_valid, 1'b0);
    issue(32'h00028493, 32'h4100);
    chk("flush_wb_done", regReadData0, 32'h5555);

    // ---- reset in the middle of a hold ----
    issue(32'h00218233, 32'h5000);
    ex_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_hold", {id_valid, pc_out}, {1'b1, 32'h5000});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ex_ready = 1'b1;
    chk("mid_rst_ctrl", {id_valid, illegal}, 2'b00);
    chk("mid_rst_fields", {opcode, func3, func7, rd}, 22'h0);
    chk("mid_rst_imm_pc", {imm, pc_out}, 64'h0);
    chk("mid_rst_data", {regReadData0, regReadData1a}, 64'h0);
    issue(32'h00218233, 32'h5004);
    chk("rst_rf_cleared", {regReadData0, regReadData1a}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
